// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state codes and byte-enable helper for the imem slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [2:0] slv_state_t;

    localparam slv_state_t SLV_IDLE = 3'd0;
    localparam slv_state_t SLV_WAIT = 3'd1;
    localparam slv_state_t SLV_LAST = 3'd2;
    localparam slv_state_t SLV_ERR1 = 3'd3;
    localparam slv_state_t SLV_ERR2 = 3'd4;

    // Oversized transfers collapse to a full word; misaligned half/word align down.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slv_sram.sv
// Word-wide SRAM behind the imem slave: byte-enable write port, registered read port.
module ahb_slv_sram #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read returns the pre-write word on a same-cycle collision; the top overlays new bytes.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_imem_slave.sv
// AHB-Lite responder for the on-chip instruction/data SRAM with programmable wait states.
// Define AHB_SLV_ERR_RESP_EN to return two-cycle ERROR responses for bad size/alignment/range.
module ahb_imem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

    slv_state_t    r_state;
    slv_state_t    w_state_d;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_d;
    logic          r_write;
    logic [AW-1:0] r_index;
    logic [3:0]    r_be;
    logic [3:0]    r_fwd_be;
    logic [31:0]   r_fwd_data;
    logic [31:0]   r_hrdata;
    logic [AW-1:0] w_index;
    logic [31:0]   w_ram_rdata;
    logic [31:0]   w_rd_word;
    logic          w_accept;
    logic          w_err;
    logic          w_we;
    logic          w_rd_active;

    assign w_index   = AW'((HADDR - BASE_ADDR) >> 2);
    assign HREADYOUT = !(r_state == SLV_WAIT || r_state == SLV_ERR1);
    // Own HREADYOUT gates acceptance so a stretched phase never swallows a new address.
    assign w_accept  = HSEL && HREADY && HREADYOUT &&
                       (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

`ifdef AHB_SLV_ERR_RESP_EN
    logic [31:0] w_offset;
    logic        w_size_bad;
    logic        w_misalign;
    logic        w_range_bad;

    assign w_offset    = HADDR - BASE_ADDR;
    assign w_size_bad  = HSIZE > HSIZE_WORD;
    assign w_misalign  = (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) ||
                         (HSIZE == HSIZE_HALF && HADDR[0]);
    assign w_range_bad = (HADDR < BASE_ADDR) ||
                         ({32'h0, w_offset} >= 64'(MEM_WORDS) * 64'd4);
    assign w_err       = w_size_bad || w_misalign || w_range_bad;
    assign HRESP       = (r_state == SLV_ERR1 || r_state == SLV_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign w_err = 1'b0;
    assign HRESP = HRESP_OKAY;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            SLV_WAIT: begin
                w_cnt_d = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_d = SLV_LAST;
                end
            end
            SLV_ERR1: begin
                w_state_d = SLV_ERR2;
            end
            default: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_d = SLV_ERR1;
                        w_cnt_d   = 3'd0;
                    end else if (WAIT_STATES == 0) begin
                        w_state_d = SLV_LAST;
                        w_cnt_d   = 3'd0;
                    end else begin
                        w_state_d = SLV_WAIT;
                        w_cnt_d   = WAIT_INIT;
                    end
                end else begin
                    w_state_d = SLV_IDLE;
                end
            end
        endcase
    end

    assign w_we        = (r_state == SLV_LAST) && r_write;
    assign w_rd_active = (r_state == SLV_LAST) && !r_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SLV_IDLE;
            r_cnt      <= 3'd0;
            r_write    <= 1'b0;
            r_index    <= '0;
            r_be       <= 4'h0;
            r_fwd_be   <= 4'h0;
            r_fwd_data <= 32'h0;
            r_hrdata   <= 32'h0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_write    <= HWRITE;
                r_index    <= w_index;
                r_be       <= byte_enables(HSIZE, HADDR[1:0]);
                // Capture bytes of a write committing on the same edge as this address phase.
                r_fwd_be   <= (w_we && r_index == w_index) ? r_be : 4'h0;
                r_fwd_data <= HWDATA;
            end
            if (w_rd_active) begin
                r_hrdata <= w_rd_word;
            end
        end
    end

    always_comb begin
        w_rd_word = w_ram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (r_fwd_be[b]) begin
                w_rd_word[8*b +: 8] = r_fwd_data[8*b +: 8];
            end
        end
    end

    assign HRDATA = w_rd_active ? w_rd_word : r_hrdata;

    ahb_slv_sram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_waddr (r_index),
        .i_wdata (HWDATA),
        .i_re    (w_accept && !w_err),
        .i_raddr (w_index),
        .o_rdata (w_ram_rdata)
    );

endmodule
